// File: rtl/uart_tx_streamer.sv
// Byte FIFO feeding a UART transmitter (8N1 by default).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_streamer #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   ovf_clr,
  output logic                   full,
  output logic                   almost_full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx,
  output logic                   tx_busy
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DIV);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt_c;
  logic          push_c;
  logic          pop_c;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_end_c;
  logic          line_c;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  // A full FIFO refuses the write even if the FSM pops on the same edge.
  assign push_c     = wr_en & ~full;
  assign pop_c      = (state == S_IDLE) & ~empty;
  assign baud_end_c = (baud_cnt == CW'(DIV - 1));

  always_comb begin
    count_nxt_c = count;
    if (push_c && !pop_c) begin
      count_nxt_c = count + (AW+1)'(1);
    end else if (pop_c && !push_c) begin
      count_nxt_c = count - (AW+1)'(1);
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags and sticky overflow, all updated with the push/pop edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= (AF_LEVEL == 0);
      overflow    <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count_nxt_c;
      empty       <= (count_nxt_c == '0);
      full        <= (count_nxt_c == (AW+1)'(DEPTH));
      almost_full <= (count_nxt_c >= (AW+1)'(AF_LEVEL));
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serial level implied by the current state; registered into tx one cycle later.
  always_comb begin
    line_c = 1'b1;
    case (state)
      S_START:  line_c = 1'b0;
      S_DATA:   line_c = shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_c = parity;
`endif
      default:  line_c = 1'b1;
    endcase
  end

  // Frame sequencer; the baud counter restarts at zero on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      tx       <= line_c;
      tx_busy  <= (state != S_IDLE);
      baud_cnt <= baud_end_c ? '0 : baud_cnt + CW'(1);
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop_c) begin
            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity <= ^mem[rd_ptr];
`endif
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_end_c) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_end_c) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end_c) begin
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_end_c) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Randomized bench for uart_tx_streamer: a queue-and-schedule model predicts every output each cycle.
module tb_uart_tx_streamer;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 2;
  localparam int DIV      = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int   NB        = 11;
  localparam int   FRAME_END = 112;
  localparam logic A5_BIT9   = 1'b0;
`else
  localparam int   NB        = 10;
  localparam int   FRAME_END = 102;
  localparam logic A5_BIT9   = 1'b1;
`endif
  localparam int PERIOD = NB * DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       full, almost_full, empty, overflow, tx, tx_busy;
  logic [2:0] count;

  uart_tx_streamer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .full(full), .almost_full(almost_full), .empty(empty), .count(count),
    .overflow(overflow), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: FIFO as a queue; line as the frame of the most recent pop at edge m_e.
  int          cyc    = 0;
  int          m_free = 0;
  int          m_e    = -100000;
  logic [10:0] m_frame = '1;
  logic [7:0]  m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_push, m_drop, m_pop;
  logic [7:0]  m_b;
  int          c_rel;
  logic        c_busy, c_tx;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_free = 0;
      m_e    = -100000;
    end else begin
      cyc++;
      m_push = wr_en && (m_q.size() < DEPTH);
      m_drop = wr_en && (m_q.size() == DEPTH);
      m_pop  = (cyc >= m_free) && (m_q.size() > 0);
      if (m_pop) begin
        m_b = m_q.pop_front();
        m_e = cyc;
        m_free = cyc + NB * DIV + 1;
`ifdef UART_TX_PARITY_EN
        m_frame = {1'b1, ^m_b, m_b, 1'b0};
`else
        m_frame = 11'({1'b1, m_b, 1'b0});
`endif
      end
      if (m_push) m_q.push_back(wr_data);
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    c_rel  = cyc - 1 - m_e;
    c_busy = (c_rel >= 0) && (c_rel < NB * DIV);
    c_tx   = c_busy ? m_frame[4'(c_rel / DIV)] : 1'b1;
    chk("tx", int'(tx), int'(c_tx));
    chk("tx_busy", int'(tx_busy), int'(c_busy));
    chk("count", int'(count), m_q.size());
    chk("empty", int'(empty), int'(m_q.size() == 0));
    chk("full", int'(full), int'(m_q.size() == DEPTH));
    chk("almost_full", int'(almost_full), int'(m_q.size() >= AF_LEVEL));
    chk("overflow", int'(overflow), int'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(m_q.size() == 0 && cyc >= m_free) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_in_time", int'(n < limit), 1);
  endtask

  // Observe one frame written at edge e0: fall offset, busy-low offset, data and bit after data.
  task automatic watch_frame(input int e0, output int fall, output int blo,
                             output logic [7:0] dat, output logic b9);
    int off;
    fall = -1; blo = -1; dat = 8'h00; b9 = 1'b0;
    for (int n = 0; n < 150 && blo < 0; n++) begin
      @(negedge clk);
      off = cyc - e0;
      if (fall < 0) begin
        if (tx == 1'b0) fall = off;
      end else begin
        for (int j = 0; j < 8; j++)
          if (off == fall + DIV * (j + 1) + DIV / 2) dat[3'(j)] = tx;
        if (off == fall + DIV * 9 + DIV / 2) b9 = tx;
        if (tx_busy == 1'b0) blo = off;
      end
    end
  endtask

  task automatic watch_burst(input int e0, output int r0, output int r1, output int r2,
                             output int peak, output logic emp_pre, output logic emp_post);
    int off, nr;
    logic pb;
    r0 = -1; r1 = -1; r2 = -1; peak = 0; nr = 0; pb = 1'b0; emp_pre = 1'b1; emp_post = 1'b0;
    for (int n = 0; n < 3 * PERIOD + 20; n++) begin
      @(negedge clk);
      off = cyc - e0;
      if (tx_busy && !pb) begin
        if (nr == 0) r0 = off;
        else if (nr == 1) r1 = off;
        else if (nr == 2) r2 = off;
        nr++;
      end
      pb = tx_busy;
      if (int'(count) > peak) peak = int'(count);
      if (off == 2 * PERIOD) emp_pre = empty;
      if (off == 2 * PERIOD + 2) emp_post = empty;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int fall, blo, e0, r0, r1, r2, peak, n, pct;
    logic [7:0] dat;
    logic b9, emp_pre, emp_post, seen;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b1;
    tick(); tick();

    // Single byte 0xA5 into an idle streamer.
    e0 = cyc + 1;
    wr_en = 1'b1; wr_data = 8'hA5; tick(); wr_en = 1'b0;
    watch_frame(e0, fall, blo, dat, b9);
    chk("a5_fall_offset", fall, 2);
    chk("a5_busy_low_offset", blo, FRAME_END);
    chk("a5_data", int'(dat), 8'hA5);
    chk("a5_bit_after_data", int'(b9), int'(A5_BIT9));

    // 0x07: odd number of ones, parity bit 1 when enabled.
    tick();
    e0 = cyc + 1;
    wr_en = 1'b1; wr_data = 8'h07; tick(); wr_en = 1'b0;
    watch_frame(e0, fall, blo, dat, b9);
    chk("p07_busy_low_offset", blo, FRAME_END);
    chk("p07_data", int'(dat), 8'h07);
    chk("p07_bit_after_data", int'(b9), 1);

    // Burst of three on consecutive edges.
    tick();
    e0 = cyc + 1;
    fork
      begin
        wr_en = 1'b1; wr_data = 8'h31; tick();
        wr_data = 8'h32; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
      end
      watch_burst(e0, r0, r1, r2, peak, emp_pre, emp_post);
    join
    chk("burst_start0", r0, 2);
    chk("burst_start1", r1, 2 + PERIOD);
    chk("burst_start2", r2, 2 + 2 * PERIOD);
    chk("burst_peak", peak, 2);
    chk("burst_empty_before_3rd_pop", int'(emp_pre), 0);
    chk("burst_empty_after_3rd_pop", int'(emp_post), 1);

    // Overflow: six pushes while the first byte goes out.
    tick();
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(65 + i);
      tick();
      if (i == 4) chk("ovf_not_yet", int'(overflow), 0);
    end
    wr_en = 1'b0;
    chk("ovf_count", int'(count), 4);
    chk("ovf_full", int'(full), 1);
    chk("ovf_af", int'(almost_full), 1);
    chk("ovf_flag", int'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    wait_idle(1000);

    // Write while full on the very edge the idle FSM pops.
    tick();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(16 * i + 3);
      tick();
    end
    wr_en = 1'b0;
    chk("sim_pre_full", int'(full), 1);
    n = 0;
    while (cyc != m_free - 1 && n < 300) begin tick(); n++; end
    wr_en = 1'b1; wr_data = 8'hEE; tick(); wr_en = 1'b0;
    chk("sim_count", int'(count), 3);
    chk("sim_ovf", int'(overflow), 1);
    chk("sim_full", int'(full), 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    wait_idle(1000);

    // Reset 50 clocks into a frame with bytes still queued.
    tick();
    e0 = cyc + 1;
    wr_en = 1'b1; wr_data = 8'h5A; tick();
    wr_data = 8'h96; tick();
    wr_data = 8'hC3; tick();
    wr_en = 1'b0;
    while (cyc < e0 + 51) tick();
    chk("rr_pre_busy", int'(tx_busy), 1);
    chk("rr_pre_count", int'(count), 2);
    rst = 1'b0;
    #1;
    chk("rr_tx", int'(tx), 1);
    chk("rr_busy", int'(tx_busy), 0);
    chk("rr_count", int'(count), 0);
    chk("rr_empty", int'(empty), 1);
    repeat (3) tick();
    rst = 1'b1;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (tx_busy || !tx) seen = 1'b1;
    end
    chk("rr_no_residual", int'(seen), 0);

    // Random traffic at three densities.
    tick();
    for (int seg = 0; seg < 3; seg++) begin
      pct = (seg == 0) ? 2 : (seg == 1) ? 15 : 70;
      for (int k = 0; k < 1500; k++) begin
        wr_en   = ($urandom_range(99) < pct);
        wr_data = 8'($urandom);
        ovf_clr = ($urandom_range(63) == 0);
        tick();
      end
    end
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    wait_idle(2000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
